// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR host controller and the filter.
package fir_pkg;

   localparam int NTAPS  = 64;     // coefficient words per run
   localparam int NSAMP  = 10064;  // data words per run (at most 16384)
   localparam int NOUT   = 10063;  // filter results collected per run
   localparam int ADDR_W = 14;     // filter write address width
   localparam int DATA_W = 16;     // coefficient / sample width
   localparam int ACC_W  = 32;     // filter result width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COEF  = 3'd1,
      ST_CTAIL = 3'd2,
      ST_DATA  = 3'd3,
      ST_DTAIL = 3'd4,
      ST_RUN   = 3'd5
   } fir_state_e;

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous result FIFO. A push into a full FIFO is accepted only when a pop
// happens on the same edge, so the caller decides about drops.
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic [ACC_W-1:0] i_data,
   input  logic             i_pop,
   output logic [ACC_W-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ACC_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   assign o_data  = r_mem[r_rd_ptr];

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; reset empties the FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + 1'b1;
         end else if (w_rd && !w_wr) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_host_ctrl.sv
// Host-side sequencer for the FIR filter: loads coefficients then data words from
// an input stream, waits for the filter results and buffers them into an output stream.
module fir_host_ctrl
   import fir_pkg::*;
#(
   parameter int NTAPS      = fir_pkg::NTAPS,
   parameter int NSAMP      = fir_pkg::NSAMP,
   parameter int NOUT       = fir_pkg::NOUT,
   parameter int FIFO_DEPTH = 8
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              cload,
   output logic              dload,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   input  logic [ACC_W-1:0]  fir_dout,
   input  logic              fir_valid,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ACC_W-1:0]  m_data,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(NTAPS - 1);
   localparam logic [ADDR_W-1:0] LAST_SAMP = ADDR_W'(NSAMP - 1);
   localparam logic [ADDR_W-1:0] LAST_OUT  = ADDR_W'(NOUT - 1);

   fir_state_e        r_state;
   fir_state_e        w_state_next;

   logic              r_cload;
   logic              r_dload;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic              r_s_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_ovf;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_out_cnt;
   logic              r_fv_d;

   logic              w_cload_next;
   logic              w_dload_next;
   logic [ADDR_W-1:0] w_addr_next;
   logic [DATA_W-1:0] w_din_next;
   logic              w_s_ready_next;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_ovf_next;
   logic [ADDR_W-1:0] w_idx_next;
   logic [ADDR_W-1:0] w_out_cnt_next;

   logic              w_hs;
   logic              w_idx_last;
   logic              w_capture;
   logic              w_pop;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;

   assign w_hs       = s_valid && r_s_ready;
   assign w_idx_last = (r_state == ST_COEF) ? (r_idx == LAST_COEF) : (r_idx == LAST_SAMP);
   // Only a rising edge of fir_valid counts, so a held level yields one result.
   assign w_capture  = (r_state == ST_RUN) && fir_valid && !r_fv_d;
   assign w_pop      = !w_empty && m_ready;
   assign w_drop     = w_capture && w_full && !w_pop;

   assign cload   = r_cload;
   assign dload   = r_dload;
   assign addr    = r_addr;
   assign din     = r_din;
   assign s_ready = r_s_ready;
   assign busy    = r_busy;
   assign done    = r_done;
   assign ovf     = r_ovf;
   assign m_valid = !w_empty;

   fir_out_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_capture),
      .i_data  (fir_dout),
      .i_pop   (w_pop),
      .o_data  (m_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: each load phase ends on its last handshake, RUN on the last capture.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_COEF;
         ST_COEF:  if (w_hs && w_idx_last) w_state_next = ST_CTAIL;
         ST_CTAIL: w_state_next = ST_DATA;
         ST_DATA:  if (w_hs && w_idx_last) w_state_next = ST_DTAIL;
         ST_DTAIL: w_state_next = ST_RUN;
         ST_RUN:   if (w_capture && (r_out_cnt == LAST_OUT)) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Output logic: next values of every registered output, strobes follow the next state
   // so cload/dload change on the same edge as the state.
   always_comb begin
      w_cload_next   = (w_state_next == ST_IDLE) || (w_state_next == ST_COEF) ||
                       (w_state_next == ST_CTAIL);
      w_dload_next   = (w_state_next == ST_DATA) || (w_state_next == ST_DTAIL);
      w_s_ready_next = (w_state_next == ST_COEF) || (w_state_next == ST_DATA);
      w_busy_next    = (w_state_next != ST_IDLE);
      w_done_next    = (r_state == ST_RUN) && (w_state_next == ST_IDLE);
      w_addr_next    = r_addr;
      w_din_next     = r_din;
      w_idx_next     = r_idx;
      w_out_cnt_next = r_out_cnt;
      w_ovf_next     = r_ovf;
      case (r_state)
         ST_IDLE: begin
            w_addr_next    = '0;
            w_din_next     = '0;
            w_idx_next     = '0;
            w_out_cnt_next = '0;
            if (start) w_ovf_next = 1'b0;
         end
         ST_COEF, ST_DATA: begin
            if (w_hs) begin
               w_addr_next = r_idx;
               w_din_next  = s_data;
               w_idx_next  = w_idx_last ? '0 : r_idx + 1'b1;
            end
         end
         ST_CTAIL: begin
            // Data phase starts writing at address 0.
            w_addr_next = '0;
            w_din_next  = '0;
         end
         ST_RUN: begin
            if (w_capture) begin
               w_out_cnt_next = (r_out_cnt == LAST_OUT) ? '0 : r_out_cnt + 1'b1;
            end
            if (w_drop) w_ovf_next = 1'b1;
            if (w_state_next == ST_IDLE) begin
               w_addr_next = '0;
               w_din_next  = '0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs, counters and the fir_valid edge detector.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cload   <= 1'b1;
         r_dload   <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
         r_s_ready <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_idx     <= '0;
         r_out_cnt <= '0;
         r_fv_d    <= 1'b0;
      end else begin
         r_cload   <= w_cload_next;
         r_dload   <= w_dload_next;
         r_addr    <= w_addr_next;
         r_din     <= w_din_next;
         r_s_ready <= w_s_ready_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_ovf     <= w_ovf_next;
         r_idx     <= w_idx_next;
         r_out_cnt <= w_out_cnt_next;
         r_fv_d    <= fir_valid;
      end
   end

endmodule

// File: tb/tb_fir_host_ctrl.sv
// Directed bench for fir_host_ctrl with NTAPS=4, NSAMP=8, NOUT=7, FIFO_DEPTH=4.
module tb_fir_host_ctrl;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        cload;
   logic        dload;
   logic [13:0] addr;
   logic [15:0] din;
   logic [31:0] fir_dout;
   logic        fir_valid;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        busy;
   logic        done;
   logic        ovf;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] got[$];
   int          got_rd   = 0;
   int          done_cnt = 0;

   typedef struct packed {
      logic        st;
      logic        sv;
      logic [15:0] sd;
      logic        cl;
      logic        dl;
      logic [13:0] ad;
      logic [15:0] di;
      logic        sr;
   } vec_t;

   vec_t tbl[15];

   fir_host_ctrl #(
      .NTAPS      (4),
      .NSAMP      (8),
      .NOUT       (7),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .cload     (cload),
      .dload     (dload),
      .addr      (addr),
      .din       (din),
      .fir_dout  (fir_dout),
      .fir_valid (fir_valid),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: records popped results and done pulses mid-cycle.
   always @(negedge clk) begin
      if (rstn) begin
         if (m_valid && m_ready) begin
            got.push_back(m_data);
            $display("pop result %0d", m_data);
         end
         if (done) done_cnt = done_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   function automatic vec_t mkv(input logic st, input logic sv, input int sd, input logic cl,
                                input logic dl, input int ad, input int di, input logic sr);
      vec_t v;
      v.st = st; v.sv = sv; v.sd = 16'(sd); v.cl = cl; v.dl = dl;
      v.ad = 14'(ad); v.di = 16'(di); v.sr = sr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cload"}, 32'(cload), 32'd1);
      chk({tag, "_dload"}, 32'(dload), 32'd0);
      chk({tag, "_addr"}, 32'(addr), 32'd0);
      chk({tag, "_din"}, 32'(din), 32'd0);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   // Start a run and stream 4 coefficients then ndata data words, optionally with a
   // 5-cycle gap after the second coefficient.
   task automatic load_run(input bit gap, input int ndata);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ovf_clear", 32'(ovf), 32'd0);
      for (int w = 0; w < 4 + ndata; w++) begin
         logic [15:0] val;
         int          k;
         val = (w < 4) ? 16'(w + 1) : 16'(10 + w - 4);
         s_valid = 1'b1;
         s_data  = val;
         k = 0;
         while (!s_ready && k < 10) begin
            tick;
            k++;
         end
         if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
         tick;
         $display("write %s addr=%0d din=%0d", (w < 4) ? "coef" : "data", addr, din);
         chk("hs_addr", 32'(addr), (w < 4) ? 32'(w) : 32'(w - 4));
         chk("hs_din", 32'(din), 32'(val));
         chk("hs_cload", 32'(cload), (w < 4) ? 32'd1 : 32'd0);
         chk("hs_dload", 32'(dload), (w < 4) ? 32'd0 : 32'd1);
         if (gap && w == 1) begin
            s_valid = 1'b0;
            repeat (5) begin
               tick;
               chk("gap_addr", 32'(addr), 32'd1);
               chk("gap_din", 32'(din), 32'd2);
               chk("gap_cload", 32'(cload), 32'd1);
            end
         end
      end
      s_valid = 1'b0;
      if (ndata == 8) begin
         tick;
         chk("run_cload", 32'(cload), 32'd0);
         chk("run_dload", 32'(dload), 32'd0);
         chk("run_s_ready", 32'(s_ready), 32'd0);
      end
   endtask

   // Deliver 7 results 100..106; the third pulse is held 3 cycles and a stray start
   // is issued during the fifth.
   task automatic run_results(input bit rdy);
      int d0;
      d0 = done_cnt;
      m_ready = rdy;
      for (int i = 0; i < 6; i++) begin
         fir_dout  = 32'(100 + i);
         fir_valid = 1'b1;
         if (i == 4) start = 1'b1;
         repeat ((i == 2) ? 3 : 1) tick;
         start     = 1'b0;
         fir_valid = 1'b0;
         tick;
         chk("run_busy", 32'(busy), 32'd1);
      end
      fir_dout  = 32'd106;
      fir_valid = 1'b1;
      tick;
      chk("end_done", 32'(done), 32'd1);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_cload", 32'(cload), 32'd1);
      chk("end_dload", 32'(dload), 32'd0);
      chk("end_addr", 32'(addr), 32'd0);
      fir_valid = 1'b0;
      tick;
      chk("end_done_clear", 32'(done), 32'd0);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
   endtask

   // Drain the FIFO and compare popped results with 100..100+n-1.
   task automatic check_results(input int n);
      m_ready = 1'b1;
      repeat (8) tick;
      chk("result_count", 32'(got.size() - got_rd), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (got_rd + i < got.size()) chk("result_data", got[got_rd + i], 32'(100 + i));
      end
      got_rd = got.size();
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      fir_dout = '0; fir_valid = 1'b0; m_ready = 1'b0;

      tbl[0]  = mkv(1, 0, 0,  1, 0, 0, 0,  1);
      tbl[1]  = mkv(0, 1, 1,  1, 0, 0, 1,  1);
      tbl[2]  = mkv(1, 1, 2,  1, 0, 1, 2,  1);   // start during COEF is ignored
      tbl[3]  = mkv(0, 1, 3,  1, 0, 2, 3,  1);
      tbl[4]  = mkv(0, 1, 4,  1, 0, 3, 4,  0);   // CTAIL
      tbl[5]  = mkv(0, 1, 10, 0, 1, 0, 0,  1);   // DATA entered, nothing accepted yet
      tbl[6]  = mkv(0, 1, 10, 0, 1, 0, 10, 1);
      tbl[7]  = mkv(0, 1, 11, 0, 1, 1, 11, 1);
      tbl[8]  = mkv(0, 1, 12, 0, 1, 2, 12, 1);
      tbl[9]  = mkv(0, 1, 13, 0, 1, 3, 13, 1);
      tbl[10] = mkv(0, 1, 14, 0, 1, 4, 14, 1);
      tbl[11] = mkv(0, 1, 15, 0, 1, 5, 15, 1);
      tbl[12] = mkv(0, 1, 16, 0, 1, 6, 16, 1);
      tbl[13] = mkv(0, 1, 17, 0, 1, 7, 17, 0);   // DTAIL
      tbl[14] = mkv(0, 0, 0,  0, 0, 7, 17, 0);   // RUN

      repeat (3) tick;
      chk_reset_vals("reset");

      // Release reset and request a run on the very same cycle.
      rstn = 1'b1;
      for (int i = 0; i < 15; i++) begin
         start   = tbl[i].st;
         s_valid = tbl[i].sv;
         s_data  = tbl[i].sd;
         tick;
         $display("vec %0d cload=%0d dload=%0d addr=%0d din=%0d s_ready=%0d",
                  i, cload, dload, addr, din, s_ready);
         chk("vec_cload", 32'(cload), 32'(tbl[i].cl));
         chk("vec_dload", 32'(dload), 32'(tbl[i].dl));
         chk("vec_addr", 32'(addr), 32'(tbl[i].ad));
         chk("vec_din", 32'(din), 32'(tbl[i].di));
         chk("vec_s_ready", 32'(s_ready), 32'(tbl[i].sr));
         chk("vec_busy", 32'(busy), 32'd1);
      end
      start = 1'b0; s_valid = 1'b0;

      run_results(1'b1);
      check_results(7);
      chk("run1_ovf", 32'(ovf), 32'd0);

      // Coefficient stream with a gap.
      load_run(1'b1, 8);
      run_results(1'b1);
      check_results(7);

      // Consumer stalled during the whole run: only FIFO_DEPTH results survive.
      load_run(1'b0, 8);
      run_results(1'b0);
      chk("stall_ovf", 32'(ovf), 32'd1);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      check_results(4);
      chk("stall_ovf_sticky", 32'(ovf), 32'd1);

      // Next start clears ovf; abort with reset at data index 5.
      load_run(1'b0, 6);
      chk("abort_addr", 32'(addr), 32'd5);
      rstn = 1'b0;
      #1;
      chk_reset_vals("abort");
      tick;
      rstn = 1'b1;
      load_run(1'b0, 8);
      run_results(1'b1);
      check_results(7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fir_host_ctrl.md
FIR_HOST_CTRL -- requirements
Module: fir_host_ctrl

Interface
REQ-001 Parameter NTAPS, default 64, number of coefficient words loaded per run.
REQ-002 Parameter NSAMP, default 10064, number of data words loaded per run (≤16384).
REQ-003 Parameter NOUT, default 10063, number of filter results collected per run.
REQ-004 Parameter FIFO_DEPTH, default 8, result FIFO depth (power of 2).
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a run; ignored unless IDLE.
REQ-008 s_valid / s_ready / s_data  in / out / in  1/1/16  input word stream, coefficients then data.
REQ-009 cload / dload  out  1/1  filter coefficient-load / data-load strobes.
REQ-010 addr  out  14  filter write address.
REQ-011 din  out  16  filter write data.
REQ-012 fir_dout / fir_valid  in  32/1  filter result and result-valid.
REQ-013 m_valid / m_ready / m_data  out / in / out  1/1/32  result output stream.
REQ-014 busy / done / ovf  out  1/1/1  run active / one-cycle end-of-run pulse / sticky result-drop flag.

Function
REQ-015 States: IDLE, COEF, CTAIL, DATA, DTAIL, RUN; all outputs registered.
REQ-016 At least one of cload/dload SHALL be 1 in every state except RUN, so the filter never starts early.
REQ-017 IDLE: cload=1, dload=0, addr=0, din=0, s_ready=0, busy=0; start -> COEF, ovf cleared, counters cleared.
REQ-018 COEF: cload=1, s_ready=1; each s_valid&&s_ready handshake sets addr=word index, din=s_data; addr/din held between handshakes.
REQ-019 The NTAPS-th coefficient handshake -> CTAIL (one cycle, s_ready=0, cload=1, addr/din held), so the last write is not lost.
REQ-020 CTAIL -> DATA: cload=0, dload=1, addr=0, din=0 on the same edge.
REQ-021 DATA: dload=1, s_ready=1; handshake sets addr=index 0..NSAMP-1, din=s_data; the NSAMP-th handshake -> DTAIL.
REQ-022 DTAIL: one cycle, dload=1, s_ready=0; then -> RUN with cload=0, dload=0.
REQ-023 RUN: a 0->1 transition of fir_valid sampled on clk SHALL push fir_dout into the FIFO; a level held over several cycles counts once.
REQ-024 FIFO full at a capture: result dropped, ovf set sticky until next start; result still counted.
REQ-025 After NOUT captures -> IDLE, cload=1 on the same edge, done=1 for exactly one cycle; the FIFO keeps draining in IDLE.
REQ-026 m_valid=1 while the FIFO is non-empty; a pop occurs on m_valid&&m_ready; output order equals capture order.
REQ-027 Simultaneous push and pop when full: both occur, no drop, no ovf.
REQ-028 busy=1 in every state except IDLE; s_ready=0 outside COEF/DATA.
REQ-029 Index counters 14 bits; NTAPS-1 and NSAMP-1 are terminal values, with no wrap inside a run.

Reset
REQ-030 rstn low, at any time including mid-run: state=IDLE, cload=1, dload=0, addr=0, din=0, s_ready=0, FIFO emptied, m_valid=0, busy=0, done=0, ovf=0, counters=0.
REQ-031 After rstn deassertion, the first start is accepted on the first rising edge.

Structure
REQ-032 Package fir_pkg holds NTAPS, NSAMP, NOUT, ADDR_W=14, DATA_W=16, ACC_W=32 and the state enum, shared with the filter.
REQ-033 Result buffering SHALL be a separate sub-module fir_out_fifo (synchronous, width ACC_W, depth FIFO_DEPTH, full/empty flags).

Verification (NTAPS=4, NSAMP=8, NOUT=7 unless stated)
REQ-034 Stream coefficients 1,2,3,4 then data 10..17 with no gaps -> addr/din sequence cload:(0,1)..(3,4), dload:(0,0),(0,10)..(7,17); cload/dload never both 0 before RUN.
REQ-035 Withdraw s_valid for 5 cycles after coefficient 2 -> addr=1, din=2 held with cload=1; the run completes identically.
REQ-036 In RUN, pulse fir_valid 7 times with fir_dout=100..106, one pulse held 3 cycles, m_ready=1 -> m_data 100..106 in order, done pulse after the 7th result, state IDLE.
REQ-037 m_ready=0 for the whole of RUN, FIFO_DEPTH=4 -> results 100..103 kept, 104..106 dropped, ovf=1, done still pulses; the next start clears ovf.
REQ-038 Assert rstn low during DATA at index 5 -> all outputs reach reset values immediately; a new start then reloads from coefficient index 0.
REQ-039 Assert start during COEF and RUN -> no effect on state or counters.
